// File: rtl/ibis_tmds_pkg.sv
// ibis_tmds_pkg: shared TMDS lane constants, control tokens and receiver FSM encoding.
package ibis_tmds_pkg;
  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;
endpackage

// File: rtl/ibis_tmds_symbol_decode.sv
// ibis_tmds_symbol_decode: maps one 10-bit TMDS symbol to token flag, control bits and pixel byte.
module ibis_tmds_symbol_decode
  import ibis_tmds_pkg::*;
(
  input  logic [SYM_W-1:0] q,
  output logic             is_token,
  output logic [1:0]       control,
  output logic [7:0]       data
);
  logic [7:0] t;
  always_comb begin
    t = q[9] ? ~q[7:0] : q[7:0];
    data = '0;
    data[0] = t[0];
    for (int i = 1; i < 8; i++) data[i] = q[8] ? t[i] ^ t[i-1] : ~(t[i] ^ t[i-1]);
    is_token = q == TOK_00 || q == TOK_01 || q == TOK_10 || q == TOK_11;
    control = q == TOK_01 ? 2'b01 : q == TOK_10 ? 2'b10 : q == TOK_11 ? 2'b11 : 2'b00;
  end
endmodule

// File: rtl/ibis_tmds_recv.sv
// ibis_tmds_recv: one TMDS lane receiver; LSB-first deserialiser, token-based symbol
// alignment (SEARCH/VERIFY/LOCKED) and registered symbol decode.
module ibis_tmds_recv
  import ibis_tmds_pkg::*;
#(
  parameter int CTRL_RUN   = 8,
  parameter int LOSS_LIMIT = 4096
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       enable,
  input  logic       in_serial,
  output logic       out_valid,
  output logic       data_enable,
  output logic [1:0] control,
  output logic [7:0] data,
  output logic       locked
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int LW = $clog2(LOSS_LIMIT + 1);
  // win[0] is the oldest bit, so only nine history bits need storing
  logic [8:0] sr_q, sr_d;
  logic [SYM_W-1:0] win;
  logic [3:0] phase_q, phase_d;
  logic [RW-1:0] run_q, run_d;
  logic [LW-1:0] loss_q, loss_d;
  state_e state_q, state_d;
  logic valid_q, valid_d, de_q, de_d, done, tok;
  logic [1:0] ctrl_q, ctrl_d, tok_ctrl;
  logic [7:0] data_q, data_d, tok_data;
  assign win = {in_serial, sr_q};
  ibis_tmds_symbol_decode u_dec (.q(win), .is_token(tok), .control(tok_ctrl), .data(tok_data));
  always_comb begin
    sr_d = enable ? win[9:1] : sr_q;
    done = enable && phase_q == 4'd9;
    phase_d = !enable ? phase_q : done ? 4'd0 : phase_q + 4'd1;
    state_d = state_q;
    run_d = run_q;
    loss_d = loss_q;
    valid_d = done && state_q == LOCKED;
    de_d = valid_d ? !tok : de_q;
    ctrl_d = valid_d && tok ? tok_ctrl : ctrl_q;
    data_d = valid_d && !tok ? tok_data : data_q;
    case (state_q)
      SEARCH: if (enable && tok) begin
        phase_d = '0;
        run_d = RW'(1);
        state_d = VERIFY;
      end
      VERIFY: if (done && !tok) begin
        run_d = '0;
        state_d = SEARCH;
      end else if (done) begin
        run_d = run_q + RW'(1);
        if (run_d == RW'(CTRL_RUN)) begin
          state_d = LOCKED;
          loss_d = '0;
        end
      end
      LOCKED: if (done) begin
        loss_d = tok ? '0 : loss_q + LW'(1);
        if (loss_d == LW'(LOSS_LIMIT)) begin
          state_d = SEARCH;
          run_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sr_q <= '0;
      phase_q <= '0;
      run_q <= '0;
      loss_q <= '0;
      state_q <= SEARCH;
      valid_q <= 1'b0;
      de_q <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      sr_q <= sr_d;
      phase_q <= phase_d;
      run_q <= run_d;
      loss_q <= loss_d;
      state_q <= state_d;
      valid_q <= valid_d;
      de_q <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign data_enable = de_q;
  assign control = ctrl_q;
  assign data = data_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_ibis_tmds_recv.sv
// tb_ibis_tmds_recv: directed bench for ibis_tmds_recv with a strobe scoreboard
// fed by an independent symbol decode model.
module tb_ibis_tmds_recv;
  logic aclk = 1'b0, areset = 1'b0, enable = 1'b1, in_serial = 1'b0;
  logic out_valid, data_enable, locked;
  logic [1:0] control;
  logic [7:0] data;
  int total = 0, bad = 0, strobes = 0, s0 = 0;
  logic [10:0] sb[$];
  logic [10:0] mon_e;
  logic [1:0] m_ctrl = 2'b00;
  logic [7:0] m_data = 8'h00;
  logic [9:0] q6;

  ibis_tmds_recv #(.CTRL_RUN(8), .LOSS_LIMIT(16)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .in_serial(in_serial),
    .out_valid(out_valid), .data_enable(data_enable), .control(control),
    .data(data), .locked(locked)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tok_code(input logic [9:0] q);
    case (q)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] ref_byte(input logic [9:0] q);
    logic [7:0] t, d;
    t = q[7:0] ^ {8{q[9]}};
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = t[i] ^ t[i-1] ^ ~q[8];
    return d;
  endfunction

  task automatic expect_sym(input logic [9:0] q);
    int c;
    c = tok_code(q);
    if (c >= 0) m_ctrl = c[1:0];
    else m_data = ref_byte(q);
    sb.push_back({c < 0, m_ctrl, m_data});
  endtask

  task automatic send_bit(input logic b);
    @(negedge aclk);
    enable = 1'b1;
    in_serial = b;
  endtask

  task automatic send_sym(input logic [9:0] q, input bit strobe);
    for (int i = 0; i < 10; i++) send_bit(q[i]);
    if (strobe) expect_sym(q);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      enable = 1'b0;
    end
  endtask

  always @(negedge aclk) begin
    if (!areset && out_valid) begin
      strobes++;
      chk("strobe_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sym", {data_enable, control, data}, mon_e);
      end
    end
  end

  initial begin
    #1 areset = 1'b1;
    repeat (6) begin
      @(negedge aclk);
      in_serial = 1'($urandom);
      chk("rst_out", {out_valid, data_enable, control, data, locked}, 0);
    end
    areset = 1'b0;
    repeat (30) send_bit(1'($urandom));
    repeat (20) send_bit(1'b0);
    chk("t1_locked", locked, 0);
    chk("t1_strobes", strobes, 0);

    repeat (3) send_bit(1'b0);
    repeat (7) send_sym(10'h354, 0);
    send_sym(10'h354, 0);
    chk("t2_pre_lock", locked, 0);
    idle(1);
    chk("t2_lock", locked, 1);
    send_sym(10'h100, 1);
    chk("t2_ov_early", out_valid, 0);
    idle(1);
    chk("t2_ov", out_valid, 1);
    idle(1);
    chk("t2_ov_drop", out_valid, 0);

    send_sym(10'h2FF, 1);
    send_sym(10'h0AB, 1);
    send_sym(10'h2AB, 1);
    idle(2);
    chk("t3_strobes", strobes, 4);

    s0 = strobes;
    repeat (16) send_sym(10'h100, 1);
    chk("t5_locked_before", locked, 1);
    idle(1);
    chk("t5_unlock", locked, 0);
    idle(1);
    chk("t5_strobes", strobes - s0, 16);

    s0 = strobes;
    repeat (5) send_sym(10'h154, 0);
    send_sym(10'h100, 0);
    idle(1);
    chk("t4_nolock", locked, 0);
    repeat (8) send_sym(10'h154, 0);
    chk("t4_pre_lock", locked, 0);
    idle(1);
    chk("t4_lock", locked, 1);
    chk("t4_strobes", strobes - s0, 0);

    s0 = strobes;
    repeat (15) send_sym(10'h100, 1);
    send_sym(10'h354, 1);
    repeat (3) send_sym(10'h100, 1);
    idle(1);
    chk("t5b_locked", locked, 1);
    idle(1);
    chk("t5b_strobes", strobes - s0, 19);

    q6 = 10'h1A5;
    for (int i = 0; i < 4; i++) send_bit(q6[i]);
    repeat (7) begin
      @(negedge aclk);
      enable = 1'b0;
      chk("t6_hold_ov", out_valid, 0);
      chk("t6_hold_out", {data_enable, control, data}, {1'b1, m_ctrl, m_data});
    end
    for (int i = 4; i < 10; i++) send_bit(q6[i]);
    expect_sym(q6);
    idle(2);
    chk("t6_locked_pre", locked, 1);
    for (int i = 0; i < 5; i++) send_bit(q6[i]);
    #2 areset = 1'b1;
    #1 chk("t6_async_rst", {out_valid, data_enable, control, data, locked}, 0);
    @(negedge aclk);
    areset = 1'b0;
    m_ctrl = 2'b00;
    m_data = 8'h00;
    send_sym(10'h100, 0);
    idle(1);
    chk("t6_post_rst_locked", locked, 0);
    chk("t6_post_rst_ov", out_valid, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ibis_tmds_recv.md
Name: ibis_tmds_recv

Overview:
Receive end of one TMDS lane. It deserialises one bit per enabled aclk cycle (LSB first, the inverse of the transmit pump) and finds the 10-bit symbol boundary by locking onto control tokens. Each symbol decodes to data_enable, control[1:0] and data[7:0], the inverse of the lane encoder. Three instances plus a clock-lane checker form the DVI sink used for loopback testing against the transmit path.

Parameters:
CTRL_RUN, 8, consecutive boundary-aligned control tokens needed to declare lock (legal range 2..255)
LOSS_LIMIT, 4096, consecutive locked symbols without a control token before lock is dropped (legal range 2..65535)

Ports:
aclk  input  1  bit-rate clock, one serial bit per enabled cycle
areset  input  1  asynchronous active-high reset
enable  input  1  clock enable; low freezes all state
in_serial  input  1  serial TMDS bit, first bit received is symbol bit 0
out_valid  output  1  one-cycle strobe: decoded symbol outputs updated
data_enable  output  1  1 = data symbol, 0 = control token
control  output  2  decoded control bits; held while data_enable=1
data  output  8  decoded pixel byte; held while data_enable=0
locked  output  1  symbol alignment established

Behaviour:
- Reset: all outputs 0, shift register 0, phase 0, all counters 0, FSM in SEARCH. Reset takes effect immediately, including mid-symbol or while LOCKED.
- enable=0: no shift, counters hold, out_valid=0, other outputs hold.
- Shift: on each enabled cycle, win = {in_serial, sr[9:1]}. Then sr <= win. win[0] is the oldest bit.
- Tokens (bit9..bit0): 0x354 gives ctrl 00, 0x0AB gives 01, 0x154 gives 10, 0x2AB gives 11.
- Phase counter runs 0..9 and wraps 9 to 0. A symbol completes on an enabled cycle with phase==9.
- SEARCH:
  - locked=0. On every enabled cycle, win is compared against the four tokens.
  - On a match: phase <= 0, run <= 1, next state VERIFY. The next symbol completes 10 enabled cycles later.
- VERIFY:
  - locked=0. Evaluated only at symbol completion.
  - win is a token: run increments. When run reaches CTRL_RUN, next state LOCKED and loss counter cleared.
  - win is not a token: next state SEARCH, run cleared.
- LOCKED:
  - locked=1. At each completion, a token clears the loss counter; any other symbol increments it.
  - Loss counter reaching LOSS_LIMIT: next state SEARCH and locked=0 on the following cycle. That symbol is still output.
- locked registered: rises on the cycle after the completion that ends VERIFY.
- out_valid:
  - Asserted for 1 cycle, the cycle after a completion evaluated while already in LOCKED.
  - The completion that causes the VERIFY to LOCKED transition produces no strobe.
  - Output registers update in the same cycle out_valid asserts. Latency is 1 cycle from the 10th bit being sampled.
- Decode:
  - Token symbol: data_enable=0, control=token value, data held.
  - Non-token symbol: data_enable=1, control held.
  - Byte decode: t = q[9] ? ~q[7:0] : q[7:0]; d[0]=t[0]; for i=1..7, d[i] = q[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]).
  - All 1020 non-token codes decode; there is no error flag.
- Counter widths: run is $clog2(CTRL_RUN+1) bits; loss counter is $clog2(LOSS_LIMIT+1) bits. Neither counter wraps.

Decomposition:
- Package ibis_tmds_pkg: the four token constants, the FSM state encoding (SEARCH/VERIFY/LOCKED) and the symbol width 10. The lane encoder shares the token constants from this package.
- Natural sub-module: ibis_tmds_symbol_decode, purely combinational. It maps q[9:0] to {is_token, control[1:0], data[7:0]}. The top holds the shifter, phase counter, FSM, counters and output registers.

Test Plan:
1. Assert areset with enable=1 and random in_serial -> every output is 0 throughout; deassert, send 30 random non-token bits -> locked=0, out_valid never asserts.
2. Send 3 junk bits, then 0x354 × 8 LSB-first (CTRL_RUN=8) -> locked rises 1 cycle after the 83rd bit. Then send 0x100 -> out_valid pulses 1 cycle after bit 93, with data_enable=1, data=0x00, control=00.
3. While locked, send 0x2FF, 0x0AB, 0x2AB -> three strobes: (de=1, data=0xFE), (de=0, control=01, data=0xFE), (de=0, control=11, data=0xFE).
4. With CTRL_RUN=8, send 0x154 × 5 then 0x100 -> locked stays 0, FSM returns to SEARCH; then send 0x154 × 8 -> locked=1.
5. With LOSS_LIMIT=16 and locked, send 0x100 × 16 -> 16 strobes, locked falls the cycle after the 16th completion. Repeat with a 0x354 after 15 data symbols -> locked stays 1.
6. While locked, drop enable for 7 cycles in the middle of a symbol -> outputs hold and out_valid=0, the symbol decodes correctly after resume. Pulse areset mid-symbol -> locked=0 and outputs 0 immediately.
